i2c_resp_mem8: RTL
==================

# i2c_resp_mem8

Synthesizable I2C target (responder) with a small byte-addressable register file. It sits on the I2C bus directly downstream of the Wishbone-to-I2C master: it samples the wired-AND SCL/SDA lines and drives the responder SDA term (`resp_sda_o`) that is ANDed into the bus. It replaces the behavioural slave model in system-level runs and gives the bench a cycle-accurate target for the master's write, read and repeated-start sequences.

## Interface
Parameters:
- `DEV_ADDR`, 7'h50, 7-bit target address this block ACKs.
- `DEPTH`, 16, register file depth in bytes. Must be a power of two, 2..256.

Ports:
- `clk`  in  1  system clock, same clock as the master.
- `rst`  in  1  synchronous, active-high reset.
- `scl_i`  in  1  bus SCL (wired-AND value).
- `sda_i`  in  1  bus SDA (wired-AND value, includes this block's own drive).
- `sda_o`  out  1  responder SDA drive. 0 pulls the line low; 1 releases it. Connects to `resp_sda_o`.
- `busy`  out  1  high from an addressed START until STOP or NACK-terminated idle.
- `wr_valid`  out  1  one-cycle pulse when a data byte is committed to the register file.
- `wr_ptr`  out  $clog2(DEPTH)  register index of the committed byte. Valid with `wr_valid`.
- `wr_data`  out  8  committed byte. Valid with `wr_valid`.

## Operation
- Input conditioning: `scl_i` and `sda_i` each pass through a 2-flop synchronizer, followed by one delay flop for edge detection.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high. Both are recognized in any state. Repeated START takes the same action as START.
- Bit timing: data is sampled on the detected SCL rising edge. `sda_o` changes only on the detected SCL falling edge, so this block can never create a false START or STOP.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
  - IDLE: on START go to ADDR and clear the bit counter.
  - ADDR: shift in 8 bits MSB first (7 address bits + R/W).
    - Match: drive ACK (`sda_o`=0) during the 9th clock, go to ADDR_ACK, set `busy`.
    - Mismatch: go to IGNORE with `sda_o`=1.
  - ADDR_ACK: when the 9th SCL falls, release SDA.
    - R/W=0: go to PTR.
    - R/W=1: load `mem[ptr]` into the shift register, drive its MSB, go to RD.
  - PTR: shift in 8 bits. `ptr <= byte[$clog2(DEPTH)-1:0]`; upper bits are ignored. ACK, then PTR_ACK, then WR.
  - WR: shift in 8 bits, then ACK. On the 8th-bit rising edge:
    - write `mem[ptr]`
    - pulse `wr_valid` with the old `ptr`
    - `ptr <= ptr+1` (mod DEPTH).
    - Then WR_ACK, then WR.
  - RD: shift out 8 bits. After the 8th SCL falls, release SDA and go to RD_ACK.
  - RD_ACK: sample the master bit on the 9th SCL rise; `ptr <= ptr+1` in either case.
    - 0 (ACK): load the next byte and go to RD.
    - 1 (NACK): go to IGNORE.
  - IGNORE: `sda_o`=1. Wait for START or STOP.
- STOP in any state: go to IDLE, `sda_o`=1, `busy`=0, `ptr` retained.
- Repeated START: go to ADDR, `sda_o`=1, `ptr` retained. This gives the write-pointer-then-read sequence.
- Register file resets to all zeros. `ptr` resets to 0.
- A partial byte aborted by STOP or Sr is discarded; no write occurs.

## Timing
- Reset values: `sda_o`=1, `busy`=0, `wr_valid`=0, `wr_ptr`=0, `wr_data`=0, state IDLE.
- Reset mid-transfer releases SDA on the cycle after `rst` is sampled high.
- Latency from a bus SCL edge to the resulting `sda_o` change: 4 `clk` cycles (2 sync + 1 edge detect + 1 output register).
- Requirements on the master: SCL low time ≥ 8 `clk` and high time ≥ 4 `clk`. The master's prescale must satisfy this; any realistic prescale ≥ 2 does.
- `wr_valid` asserts 4 `clk` after the bus SCL rising edge of data bit 0 (LSB).
- Simultaneous START/STOP detection and a bit event: START/STOP wins, and the bit is discarded.
- `sda_o` is registered with no combinational path from inputs.

## Test plan
- Reset: hold `rst` 3 cycles → `sda_o`=1, `busy`=0, `wr_valid`=0; a read of pointer 0 returns 0x00.
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP → 4 ACKs; `wr_valid` pulses with (3, 0x11) then (4, 0x22); `busy` falls after STOP.
- Random read: START, 0xA0, 0x03, Sr, 0xA1, read with ACK then NACK, STOP → master's `wbs_dat_o` returns 0x11 then 0x22; SDA is released in RD_ACK.
- Address mismatch: START, 0xA2, STOP → NACK, `sda_o` stays 1 throughout, `busy`=0; a following valid write to 0xA0 is ACKed.
- Pointer wrap: write pointer 0x0F, then data 0xAA, 0xBB → `wr_valid` (15, 0xAA) then (0, 0xBB); reading from 0x0F returns 0xAA, 0xBB.
- Abort:
  - STOP after 4 data bits of a write → no `wr_valid`, state IDLE.
  - `rst` asserted while `sda_o`=0 in RD → `sda_o`=1 on the next cycle.

Source files
------------

// File: rtl/i2c_resp_mem8.sv
// I2C target with a small byte-addressable register file.
// Samples the wired-AND SCL/SDA lines and drives an open-drain style SDA term
// (0 = pull low, 1 = release). A write sets the register pointer and then
// stores data bytes. A read, usually after a repeated START, returns bytes
// from the pointer and auto-increments it.
module i2c_resp_mem8 #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_o,
    output logic                     busy,
    output logic                     wr_valid,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [7:0]               wr_data
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        IGNORE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // Synchronizer, delay and registered-event flops
    logic           scl_s1;
    logic           scl_s2;
    logic           scl_d;
    logic           sda_s1;
    logic           sda_s2;
    logic           sda_d;
    logic           scl_rise;
    logic           scl_fall;
    logic           start_det;
    logic           stop_det;

    // Datapath
    logic [3:0]     bit_cnt;
    logic [3:0]     bit_cnt_nxt;
    logic [7:0]     shreg;
    logic [7:0]     shreg_nxt;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_nxt;
    logic           sda_nxt;
    logic           busy_nxt;
    logic           mem_we;
    logic [7:0]     rx_byte;
    logic [7:0]     mem_rd;
    logic [7:0]     mem [DEPTH];

    // Byte formed by the bit currently being sampled; the write path
    // commits it on the 8th rising edge.
    assign rx_byte = {shreg[6:0], sda_d};
    assign mem_rd  = mem[ptr];

    // Two-flop synchronizers, a delay flop, and registered bus events.
    // SDA for a data bit is taken from sda_d, which is aligned with the
    // registered SCL rising event.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_d     <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_s1    <= scl_i;
            scl_s2    <= scl_s1;
            scl_d     <= scl_s2;
            sda_s1    <= sda_i;
            sda_s2    <= sda_s1;
            sda_d     <= sda_s2;
            scl_rise  <= scl_s2 & ~scl_d;
            scl_fall  <= ~scl_s2 & scl_d;
            start_det <= scl_s2 & scl_d & sda_d & ~sda_s2;
            stop_det  <= scl_s2 & scl_d & ~sda_d & sda_s2;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decode. START/STOP take priority over any bit event.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        ptr_nxt     = ptr;
        sda_nxt     = sda_o;
        busy_nxt    = busy;
        mem_we      = 1'b0;

        if (stop_det) begin
            state_nxt = IDLE;
            sda_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_nxt     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    sda_nxt = 1'b1;
                end

                ADDR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (shreg[7:1] == DEV_ADDR) begin
                            sda_nxt   = 1'b0;
                            busy_nxt  = 1'b1;
                            state_nxt = ADDR_ACK;
                        end else begin
                            sda_nxt   = 1'b1;
                            busy_nxt  = 1'b0;
                            state_nxt = IGNORE;
                        end
                    end
                end

                ADDR_ACK: begin
                    // shreg[0] still holds R/W; the ACK clock does not shift.
                    if (scl_fall) begin
                        bit_cnt_nxt = '0;
                        if (shreg[0]) begin
                            shreg_nxt = mem_rd;
                            sda_nxt   = mem_rd[7];
                            state_nxt = RD;
                        end else begin
                            sda_nxt   = 1'b1;
                            state_nxt = PTR;
                        end
                    end
                end

                PTR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        ptr_nxt   = shreg[PW-1:0];
                        sda_nxt   = 1'b0;
                        state_nxt = PTR_ACK;
                    end
                end

                PTR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt     = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = WR;
                    end
                end

                WR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            mem_we  = 1'b1;
                            ptr_nxt = ptr + PW'(1);
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_nxt   = 1'b0;
                        state_nxt = WR_ACK;
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt     = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = WR;
                    end
                end

                RD: begin
                    // The MSB is already on the line; each later fall presents the next bit.
                    if (scl_rise && bit_cnt < 4'd8) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_nxt     = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = RD_ACK;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        sda_nxt   = shreg[6];
                        shreg_nxt = {shreg[6:0], 1'b0};
                    end
                end

                RD_ACK: begin
                    // bit_cnt=1 records a master ACK until the following fall.
                    if (scl_rise && bit_cnt == 4'd0) begin
                        ptr_nxt = ptr + PW'(1);
                        if (sda_d) begin
                            busy_nxt  = 1'b0;
                            state_nxt = IGNORE;
                        end else begin
                            bit_cnt_nxt = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        shreg_nxt   = mem_rd;
                        sda_nxt     = mem_rd[7];
                        bit_cnt_nxt = '0;
                        state_nxt   = RD;
                    end
                end

                IGNORE: begin
                    sda_nxt = 1'b1;
                end

                default: begin
                    sda_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Datapath registers and write-commit outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            sda_o    <= 1'b1;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_ptr   <= '0;
            wr_data  <= '0;
        end else begin
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            ptr      <= ptr_nxt;
            sda_o    <= sda_nxt;
            busy     <= busy_nxt;
            wr_valid <= mem_we;
            if (mem_we) begin
                wr_ptr  <= ptr;
                wr_data <= rx_byte;
            end
        end
    end

    // Register file, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[ptr] <= rx_byte;
        end
    end

endmodule
